dmem_arbiter: RTL

// - Shares the single-port data memory between the pipeline MEM stage (core) and a debug/loader port (dbg).
// - Sequences each access through command, latency-wait and done phases.
// - Freezes the pipeline with core_stall until the core access completes.
// - Sits between Datapath MEM-stage signals (rd/wr/addr/wr_data) and the data memory instance.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arb2.sv | 30 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, requester ids and latency bounds.
package dmem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t CMD  = 2'd1;
    localparam arb_state_t WAIT = 2'd2;
    localparam arb_state_t DONE = 2'd3;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

    localparam int MAX_LAT = 4;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: bit 0 is the core, bit 1 the debug port.
// The pointer names the side that wins the next tie; it resets favouring the core.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // The pointer moves when a grant is taken, away from the winner. It is not
    // consulted again until the next IDLE, so this matches moving it at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the MEM-stage core port and a debug port.
// Each access runs IDLE -> CMD -> (WAIT) -> DONE; the core is stalled until its DONE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        state
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

    arb_state_t        state_nxt;
    req_id_t           win;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [1:0]        gnt;
    logic              creq;
    logic              core_done;

    assign creq = core_rd | core_wr;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({dbg_req, creq}),
        .advance (state == IDLE),
        .gnt     (gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt != 2'b00) state_nxt = CMD;
            CMD:     state_nxt = (op_wr || MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    if (lat_cnt == LAT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            win          <= REQ_CORE;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
            lat_cnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // A core access with both rd and wr set is a write.
                    if (gnt[1]) begin
                        win     <= REQ_DBG;
                        op_wr   <= dbg_we;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                    end else if (gnt[0]) begin
                        win     <= REQ_CORE;
                        op_wr   <= core_wr;
                        addr_q  <= core_addr;
                        wdata_q <= core_wdata;
                    end
                end
                CMD:  lat_cnt <= LAT_LOAD;
                WAIT: lat_cnt <= lat_cnt - 1'b1;
                DONE: begin
                    if (!op_wr) begin
                        if (win == REQ_CORE) core_rdata_q <= mem_rdata;
                        else                 dbg_rdata_q  <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_done  = (state == DONE) && (win == REQ_CORE);
    assign core_stall = creq & ~core_done;
    assign dbg_ack    = (state == DONE) && (win == REQ_DBG);

    assign mem_rd    = (state == CMD) && !op_wr;
    assign mem_wr    = (state == CMD) && op_wr;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Read data is forwarded in DONE so it is valid as stall falls or ack pulses.
    assign core_rdata = (core_done && !op_wr) ? mem_rdata : core_rdata_q;
    assign dbg_rdata  = (dbg_ack && !op_wr)   ? mem_rdata : dbg_rdata_q;

endmodule
